// File: rtl/herald_host_master.sv
`default_nettype none
// ============================================================================
//  Module   : herald_host_master
//  Purpose  : Host-side master for the HERALD accelerator byte bus. Accepts a
//             command plus two Q12.12 operands, writes them LSB-first with
//             timed write strobes, waits for BUSY (bus_din[7]) to clear, reads
//             back the command's result bytes with timed read strobes and
//             presents them on a valid/ready response port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n            : clock, asynchronous active-low reset
//    req_valid/req_ready   : request handshake; req_cmd, req_op_a, req_op_b
//    rsp_valid/rsp_ready   : response handshake; rsp_data (byte 0 at [7:0]),
//                            rsp_err (bad command or BUSY timeout)
//    bus_dout, bus_wr      : accelerator data input and write strobe
//    bus_rd, bus_din       : accelerator read strobe and data output
//    active                : transaction in progress
//  Optional feature
//    HERALD_HOST_TIMEOUT_EN : when defined, WAIT_BUSY gives up after
//                             TIMEOUT_CYC busy cycles and reports rsp_err.
// ============================================================================
module herald_host_master #(
  parameter int STROBE_W    = 2,
  parameter int GAP_W       = 2,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_op_a,
  input  logic [23:0] req_op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [71:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  bus_dout,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  output logic        active
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_HI     = 3'd1,
    WR_LO     = 3'd2,
    CLR_WAIT  = 3'd3,
    WAIT_BUSY = 3'd4,
    RD_HI     = 3'd5,
    RD_LO     = 3'd6,
    RSP       = 3'd7
  } state_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_W - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_W - 1);
  localparam logic [7:0] CMD_CLEAR   = 8'h22;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // cycles spent in the current strobe phase
  logic [3:0]  idx_q, idx_d;        // byte index within write or read phase
  logic [3:0]  nwr_q, nwr_d;        // bytes to write, command byte included
  logic [3:0]  nrd_q, nrd_d;        // result bytes to read
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] op_a_q, op_a_d;
  logic [23:0] op_b_q, op_b_d;
  logic [71:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;

  logic        dec_ok;
  logic [3:0]  dec_nwr, dec_nrd;

  // Command table: write count includes the command byte itself.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nwr = 4'd0;
    dec_nrd = 4'd0;
    case (req_cmd)
      8'h10:                      begin dec_nwr = 4'd4; dec_nrd = 4'd6; end
      8'h11, 8'h12, 8'h20, 8'h21: begin dec_nwr = 4'd7; dec_nrd = 4'd3; end
      8'h13:                      begin dec_nwr = 4'd7; dec_nrd = 4'd9; end
      8'h23:                      begin dec_nwr = 4'd4; dec_nrd = 4'd3; end
      8'h22:                      begin dec_nwr = 4'd1; dec_nrd = 4'd0; end
      default:                    dec_ok = 1'b0;
    endcase
  end

  // Outgoing byte k of the write sequence (k >= 1; byte 0 is the command).
  function automatic logic [7:0] op_byte(input logic [3:0] k,
                                         input logic [23:0] a,
                                         input logic [23:0] b);
    case (k)
      4'd1:    op_byte = a[7:0];
      4'd2:    op_byte = a[15:8];
      4'd3:    op_byte = a[23:16];
      4'd4:    op_byte = b[7:0];
      4'd5:    op_byte = b[15:8];
      4'd6:    op_byte = b[23:16];
      default: op_byte = 8'h00;
    endcase
  endfunction

`ifdef HERALD_HOST_TIMEOUT_EN
  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYC - 1);
  logic [11:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = (state_q == WAIT_BUSY) ? tmo_q + 12'd1 : 12'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 12'd0;
    else        tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    nwr_d      = nwr_q;
    nrd_d      = nrd_q;
    cmd_d      = cmd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    dout_d     = dout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d      = req_cmd;
          op_a_d     = req_op_a;
          op_b_d     = req_op_b;
          nwr_d      = dec_nwr;
          nrd_d      = dec_nrd;
          idx_d      = 4'd0;
          cnt_d      = 4'd0;
          rsp_data_d = 72'd0;
          rsp_err_d  = ~dec_ok;
          if (dec_ok) begin
            state_d = WR_HI;
            dout_d  = req_cmd;
          end else begin
            state_d = RSP;
          end
        end
      end

      WR_HI: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = 4'd0;
          state_d = WR_LO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WR_LO: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 4'd0;
          if (idx_q + 4'd1 < nwr_q) begin
            idx_d   = idx_q + 4'd1;
            dout_d  = op_byte(idx_q + 4'd1, op_a_q, op_b_q);
            state_d = WR_HI;
          end else if (cmd_q == CMD_CLEAR) begin
            state_d = CLR_WAIT;
          end else begin
            idx_d   = 4'd0;
            state_d = WAIT_BUSY;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      CLR_WAIT: begin
        if (cnt_q == 4'd3) begin
          cnt_d   = 4'd0;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WAIT_BUSY: begin
        if (!bus_din[7]) begin
          cnt_d   = 4'd0;
          state_d = RD_HI;
        end
`ifdef HERALD_HOST_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_LAST) begin
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end
`endif
      end

      RD_HI: begin
        // Second rising edge after bus_rd rose: accelerator data is settled.
        if (cnt_q == 4'd1) begin
          rsp_data_d[{idx_q, 3'b000} +: 8] = bus_din;
        end
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = 4'd0;
          state_d = RD_LO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      RD_LO: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 4'd0;
          if (idx_q + 4'd1 < nrd_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = RD_HI;
          end else begin
            state_d = RSP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Strobes come straight from flops so they cannot glitch or overlap.
    wr_d = (state_d == WR_HI);
    rd_d = (state_d == RD_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= 4'd0;
      nwr_q      <= 4'd0;
      nrd_q      <= 4'd0;
      cmd_q      <= 8'd0;
      op_a_q     <= 24'd0;
      op_b_q     <= 24'd0;
      rsp_data_q <= 72'd0;
      rsp_err_q  <= 1'b0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      nwr_q      <= nwr_d;
      nrd_q      <= nrd_d;
      cmd_q      <= cmd_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign active    = (state_q != IDLE) && (state_q != RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign bus_dout  = dout_q;
  assign bus_wr    = wr_q;
  assign bus_rd    = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_herald_host_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_herald_host_master
//  Purpose  : Self-checking bench for herald_host_master with a small
//             accelerator responder (write logger, BUSY generator, read data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_herald_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [23:0] req_op_a = 24'h0;
  logic [23:0] req_op_b = 24'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [71:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  bus_dout;
  logic        bus_wr;
  logic        bus_rd;
  logic [7:0]  bus_din;
  logic        active;

  herald_host_master #(
    .STROBE_W(2), .GAP_W(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .bus_dout(bus_dout), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_din(bus_din),
    .active(active)
  );

  always #5 clk = ~clk;

  // ---------------- accelerator responder model ----------------
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          busy_left = 0;
  int          overlap = 0;
  logic        stuck = 1'b0;
  logic [55:0] wpk = 56'h0;
  logic [71:0] rdsrc = 72'h0;

  always @(posedge bus_wr) begin
    if (wr_cnt < 7) wpk[8*wr_cnt +: 8] = bus_dout;
    wr_cnt = wr_cnt + 1;
  end

  always @(posedge bus_rd) rd_cnt = rd_cnt + 1;

  // BUSY stays up for 3 cycles after the last write strobe is seen low.
  always @(negedge clk) begin
    if (bus_wr) busy_left = 3;
    else if (busy_left > 0) busy_left = busy_left - 1;
  end

  always @(posedge clk) if (bus_wr && bus_rd) overlap = overlap + 1;

  always_comb begin
    bus_din = {(stuck || (busy_left > 0)), 7'h00};
    if (bus_rd && rd_cnt > 0 && rd_cnt <= 9) bus_din = rdsrc[8*(rd_cnt-1) +: 8];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] a;
    logic [23:0] b;
    logic [71:0] rdsrc;
    logic [71:0] exp_data;
    logic        exp_err;
    int          exp_nwr;
    int          exp_nrd;
    int          exp_lat;   // negedges from acceptance edge to rsp_valid
    logic [55:0] exp_w;     // logged write bytes, byte 0 at [7:0]
  } vec_t;

  vec_t vecs[7];

  task automatic clear_model();
    wr_cnt = 0;
    rd_cnt = 0;
    wpk    = 56'h0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    clear_model();
    rdsrc = v.rdsrc;
    chk({tag, ".req_ready_idle"}, 72'(req_ready), 72'd1);
    req_valid = 1'b1;
    req_cmd   = v.cmd;
    req_op_a  = v.a;
    req_op_b  = v.b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!rsp_valid && n < 3000);
    chk({tag, ".rsp_valid"}, 72'(rsp_valid), 72'd1);
    chk({tag, ".latency"}, 72'(n), 72'(v.exp_lat));
    chk({tag, ".rsp_data"}, rsp_data, v.exp_data);
    chk({tag, ".rsp_err"}, 72'(rsp_err), 72'(v.exp_err));
    chk({tag, ".wr_pulses"}, 72'(wr_cnt), 72'(v.exp_nwr));
    chk({tag, ".rd_pulses"}, 72'(rd_cnt), 72'(v.exp_nrd));
    chk({tag, ".wr_bytes"}, 72'(wpk), 72'(v.exp_w));
    chk({tag, ".active_rsp"}, 72'(active), 72'd0);
    chk({tag, ".req_ready_rsp"}, 72'(req_ready), 72'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".back_idle"}, 72'({req_ready, rsp_valid}), 72'b10);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h20, 24'h001800, 24'h002000, 72'hEEEEEEEEEEEE003000,
                72'h003000, 1'b0, 7, 3, 42, 56'h00200000180020};
    vecs[1] = '{8'h13, 24'h123456, 24'hABCDEF, 72'h090807060504030201,
                72'h090807060504030201, 1'b0, 7, 9, 66, 56'hABCDEF12345613};
    vecs[2] = '{8'h10, 24'h0C8000, 24'h777777, 72'hEEEEEEA1B2C3D4E5F6,
                72'h000000A1B2C3D4E5F6, 1'b0, 4, 6, 42, 56'h0C800010};
    vecs[3] = '{8'h23, 24'h7FFFFF, 24'h000001, 72'hEEEEEEEEEEEEFEDCBA,
                72'h00000000000FEDCBA, 1'b0, 4, 3, 30, 56'h7FFFFF23};
    vecs[4] = '{8'h22, 24'h123456, 24'h654321, 72'hEEEEEEEEEEEEEEEEEE,
                72'h0, 1'b0, 1, 0, 9, 56'h22};
    vecs[5] = '{8'h55, 24'h111111, 24'h222222, 72'hEEEEEEEEEEEEEEEEEE,
                72'h0, 1'b1, 0, 0, 1, 56'h0};
    vecs[6] = '{8'h11, 24'h010203, 24'h040506, 72'hEEEEEEEEEEEE778899,
                72'h778899, 1'b0, 7, 3, 42, 56'h04050601020311};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.req_ready", 72'(req_ready), 72'd1);
    chk("reset.rsp_valid", 72'(rsp_valid), 72'd0);
    chk("reset.strobes", 72'({bus_wr, bus_rd}), 72'd0);
    chk("reset.active", 72'(active), 72'd0);
    chk("reset.rsp_data", rsp_data, 72'd0);
    chk("reset.rsp_err", 72'(rsp_err), 72'd0);
    chk("reset.bus_dout", 72'(bus_dout), 72'd0);

    // Table-driven transactions
    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Bad command under response back-pressure
    @(negedge clk);
    clear_model();
    req_valid = 1'b1;
    req_cmd   = 8'h55;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d", i), 72'({rsp_valid, req_ready, rsp_err}), 72'b101);
    end
    chk("bp.data_zero", rsp_data, 72'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.no_same_cycle_accept", 72'({req_ready, rsp_valid, active}), 72'b100);
    @(negedge clk);
    chk("bp.second_accept", 72'({rsp_valid, rsp_err}), 72'b11);
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.drained", 72'(req_ready), 72'd1);
    chk("bp.no_strobes", 72'(wr_cnt + rd_cnt), 72'd0);

    // Reset during 2nd byte of SINCOS, then a clean SINCOS
    @(negedge clk);
    clear_model();
    req_valid = 1'b1;
    req_cmd   = 8'h10;
    req_op_a  = 24'h0C8000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (wr_cnt < 2 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("rst.reached_byte2", 72'(wr_cnt), 72'd2);
    chk("rst.wr_high", 72'(bus_wr), 72'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.async_wr_low", 72'({bus_wr, bus_rd, active}), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.req_ready_after", 72'(req_ready), 72'd1);
    repeat (4) @(negedge clk);
    chk("rst.no_more_strobes", 72'(wr_cnt), 72'd2);
    run_txn(vecs[2], "rst.sincos");

`ifdef HERALD_HOST_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{8'h20, 24'h001800, 24'h002000, 72'hEEEEEEEEEEEEEEEEEE,
             72'h0, 1'b1, 7, 0, 45, 56'h00200000180020};
      stuck = 1'b1;
      run_txn(tv, "timeout");
      stuck = 1'b0;
    end
`endif

    chk("strobe_overlap", 72'(overlap), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/herald_host_master.md
HERALD_HOST_MASTER -- requirements
Module: herald_host_master

Interface
REQ-001 Parameters SHALL be: STROBE_W, 2, cycles bus_wr/bus_rd held high (legal 2..15); GAP_W, 2, cycles strobe held low after each pulse (legal 1..15); TIMEOUT_CYC, 4095, busy-wait limit in cycles (12-bit).
REQ-002 Reset SHALL be rst_n, asynchronous, active-low; clock SHALL be clk.
REQ-003 Ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-004 Ports: req_valid in 1; req_ready out 1; req_cmd in 8; req_op_a in 24 (Q12.12); req_op_b in 24 (Q12.12).
REQ-005 Ports: rsp_valid out 1; rsp_ready in 1; rsp_data out 72 (result, byte 0 at [7:0]); rsp_err out 1 (bad command or timeout).
REQ-006 Ports: bus_dout out 8 (to accelerator data input); bus_wr out 1 (to write strobe); bus_rd out 1 (to read strobe); bus_din in 8 (from accelerator output, bit 7 = BUSY); active out 1 (transaction in progress).

Function
REQ-007 Request handshake SHALL be accepted on a clk edge where req_valid && req_ready; req_ready SHALL be 1 only in IDLE; cmd/op_a/op_b SHALL be latched on acceptance.
REQ-008 Per-command operand and result byte counts SHALL be: 0x10 SINCOS 3/6; 0x11 ATAN2, 0x12 SQRT, 0x20 MULTIPLY, 0x21 MAC 6/3; 0x13 NORMALIZE 6/9; 0x23 MSU 3/3; 0x22 CLEAR 0/0.
REQ-009 An unrecognised command SHALL generate no bus activity and SHALL go straight to RSP with rsp_err=1, rsp_data=0.
REQ-010 Write sequence SHALL send: command byte, then op_a bytes [7:0],[15:8],[23:16], then (6-operand commands only) op_b in the same LSB-first order.
REQ-011 Each byte SHALL be sent as: bus_dout driven and bus_wr=1 for STROBE_W cycles (WR_HI), then bus_wr=0 for GAP_W cycles (WR_LO); bus_dout SHALL stay stable through WR_HI and WR_LO.
REQ-012 FSM states SHALL be IDLE, WR_HI, WR_LO, CLR_WAIT, WAIT_BUSY, RD_HI, RD_LO, RSP.
REQ-013 After the last WR_LO: CLEAR SHALL go to CLR_WAIT for 4 cycles, then to RSP with rsp_data=0. All other commands SHALL go to WAIT_BUSY.
REQ-014 WAIT_BUSY SHALL exit to RD_HI on the first edge that samples bus_din[7]==0.
REQ-015 Each result byte SHALL be read as: bus_rd=1 for STROBE_W cycles, then bus_rd=0 for GAP_W cycles. bus_din SHALL be captured exactly at the 2nd rising edge after bus_rd rises, into rsp_data[8k+7:8k] for byte k. Capture SHALL ignore bit 7 semantics.
REQ-016 rsp_data bits above 8*(result count) SHALL be 0.
REQ-017 RSP SHALL hold rsp_valid=1 and rsp_data/rsp_err stable until rsp_valid && rsp_ready, then return to IDLE. A new request SHALL NOT be accepted in the same cycle.
REQ-018 bus_wr and bus_rd SHALL be registered, glitch-free, and never 1 simultaneously. active SHALL be 1 in every state except IDLE and RSP.
REQ-019 Minimum MULTIPLY transaction with STROBE_W=GAP_W=2: 7x4 write cycles + WAIT_BUSY + 3x4 read cycles + 1 RSP cycle.

Reset
REQ-020 Asynchronous reset SHALL force state=IDLE and all outputs to 0, except req_ready=1 after release; bus_wr=bus_rd=0; byte counters, latched request and rsp_data SHALL be cleared.
REQ-021 Reset asserted mid-transaction SHALL abort immediately with no further strobes. The accelerator is reset by the same rst_n.

Configuration
REQ-022 Macro HERALD_HOST_TIMEOUT_EN, when defined, SHALL add a 12-bit WAIT_BUSY counter. After TIMEOUT_CYC cycles with bus_din[7]==1 the block SHALL go to RSP with rsp_err=1, rsp_data=0, and issue no reads.
REQ-023 When HERALD_HOST_TIMEOUT_EN is undefined, WAIT_BUSY SHALL wait indefinitely, rsp_err SHALL only flag bad commands, and no counter logic SHALL exist.

Verification
REQ-024 MULTIPLY: cmd 0x20, A=0x001800, B=0x002000 -> bus writes 20,00,18,00,00,20,00. Responder model returns 00,30,00 -> rsp_data=0x...003000, rsp_err=0.
REQ-025 NORMALIZE: cmd 0x13 with model returning bytes 01..09 -> exactly 9 bus_rd pulses, rsp_data=0x090807060504030201.
REQ-026 CLEAR: cmd 0x22 -> exactly one bus_wr pulse, zero bus_rd pulses, rsp_valid 4+GAP_W cycles after the strobe falls, rsp_data=0.
REQ-027 Bad command 0x55 -> no strobes, rsp_err=1. With rsp_ready held 0 for 10 cycles, rsp_valid SHALL stay high and req_ready SHALL stay 0.
REQ-028 With HERALD_HOST_TIMEOUT_EN and TIMEOUT_CYC=16, model BUSY stuck at 1 -> rsp_err=1 after 16 WAIT_BUSY cycles and no bus_rd.
REQ-029 rst_n pulsed during the 2nd operand byte of SINCOS -> bus_wr=0 asynchronously, req_ready=1 after release; the next SINCOS completes with correct 6-byte rsp_data.
